// File: rtl/mul4_tournament_sched.sv
// Tournament sequencer: drives the 2x2-multiplier truth table to NCAND candidates in turn,
// scores each candidate's captured outputs against the golden product and reports the winner.
module mul4_tournament_sched #(
    parameter int NCAND      = 8,
    parameter int SETTLE     = 2,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int SW = (NCAND > 1) ? $clog2(NCAND) : 1,
    localparam int CW = $clog2(SETTLE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [SW-1:0] cand_sel,
    output logic [15:0]   a1,
    output logic [15:0]   a0,
    output logic [15:0]   b1,
    output logic [15:0]   b0,
    input  logic [15:0]   y3,
    input  logic [15:0]   y2,
    input  logic [15:0]   y1,
    input  logic [15:0]   y0,
    output logic          busy,
    output logic          score_valid,
    output logic [6:0]    last_score,
    output logic [SW-1:0] best_idx,
    output logic [6:0]    best_score,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SAMPLE = 3'd2,
        S_SCORE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Lane i carries a = i[3:2], b = i[1:0]; GOLDEN is {y3,y2,y1,y0} of the exact product.
    localparam logic [15:0] STIM_A1 = 16'hFF00;
    localparam logic [15:0] STIM_A0 = 16'hF0F0;
    localparam logic [15:0] STIM_B1 = 16'hCCCC;
    localparam logic [15:0] STIM_B0 = 16'hAAAA;
    localparam logic [63:0] GOLDEN  = 64'h8000_4C00_6AC0_A0A0;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] cand_q, cand_d;
    logic [SW-1:0] best_idx_q, best_idx_d;
    logic [63:0]   ycap_q, ycap_d;
    logic [6:0]    best_score_q, best_score_d;
    logic [6:0]    last_score_q, last_score_d;
    logic          score_valid_q, score_valid_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [15:0]   a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
    logic [6:0]    score_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        best_idx_d    = best_idx_q;
        ycap_d        = ycap_q;
        best_score_d  = best_score_q;
        last_score_d  = last_score_q;
        score_valid_d = 1'b0;
        done_d        = 1'b0;
        score_s       = 7'd64 - popcount64(ycap_q ^ GOLDEN);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT;
                    cnt_d        = CW'(SETTLE - 1);
                    cand_d       = {SW{1'b0}};
                    best_idx_d   = {SW{1'b0}};
                    best_score_d = 7'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                ycap_d  = {y3, y2, y1, y0};
                state_d = S_SCORE;
            end
            S_SCORE: begin
                last_score_d  = score_s;
                score_valid_d = 1'b1;
                // Strictly greater: on a tie the earlier (lower) index keeps the title.
                if (score_s > best_score_q) begin
                    best_score_d = score_s;
                    best_idx_d   = cand_q;
                end else begin
                    best_score_d = best_score_q;
                end
                if ((EARLY_EXIT && (score_s == 7'd64)) || (cand_q == SW'(NCAND - 1))) begin
                    state_d = S_DONE;
                end else begin
                    cand_d  = cand_q + SW'(1);
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_WAIT) || (state_d == S_SAMPLE) || (state_d == S_SCORE);
        if (busy_d) begin
            a1_d = STIM_A1;
            a0_d = STIM_A0;
            b1_d = STIM_B1;
            b0_d = STIM_B0;
        end else begin
            a1_d = 16'h0000;
            a0_d = 16'h0000;
            b1_d = 16'h0000;
            b0_d = 16'h0000;
        end
    end

    // State and output registers; the async clear forces every output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CW{1'b0}};
            cand_q        <= {SW{1'b0}};
            best_idx_q    <= {SW{1'b0}};
            ycap_q        <= 64'd0;
            best_score_q  <= 7'd0;
            last_score_q  <= 7'd0;
            score_valid_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            a1_q          <= 16'h0000;
            a0_q          <= 16'h0000;
            b1_q          <= 16'h0000;
            b0_q          <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            best_idx_q    <= best_idx_d;
            ycap_q        <= ycap_d;
            best_score_q  <= best_score_d;
            last_score_q  <= last_score_d;
            score_valid_q <= score_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            a1_q          <= a1_d;
            a0_q          <= a0_d;
            b1_q          <= b1_d;
            b0_q          <= b0_d;
        end
    end

    assign cand_sel    = cand_q;
    assign a1          = a1_q;
    assign a0          = a0_q;
    assign b1          = b1_q;
    assign b0          = b0_q;
    assign busy        = busy_q;
    assign score_valid = score_valid_q;
    assign last_score  = last_score_q;
    assign best_idx    = best_idx_q;
    assign best_score  = best_score_q;
    assign done        = done_q;

endmodule
